// File: rtl/uart_rx_frm_if.sv
// Serial-in / byte-out bundle between the line synchronizer, uart_rx_frm and the byte loader.
// slave is the receiver's view; master is the view of whoever drives rx and consumes the byte.
interface uart_rx_frm_if;
  logic       rx;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       frm_err;
  logic       busy;

  modport master (output rx, input rx_rdy, rx_data, frm_err, busy);
  modport slave  (input rx, output rx_rdy, rx_data, frm_err, busy);
endinterface

// File: rtl/uart_rx_frm.sv
// 8N1 UART receiver: start-bit validation, framing-error strobe, one-cycle ready pulse.
// Define UART_RX_MAJ_VOTE_EN to take every bit sample as a 2-of-3 vote over the last three rx values.
module uart_rx_frm #(
  parameter int BAUD_DIV = 5208
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_frm_if.slave bus
);

  // The counter is reloaded with BAUD_DIV itself, so it needs room for that value.
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          prev_rx;
  logic          rx_rdy_q;
  logic [7:0]    rx_data_q;
  logic          frm_err_q;
  logic          s;
  logic          tick;
  logic          start_edge;

  assign tick       = (baud_cnt == CW'(1));
  assign start_edge = prev_rx & ~bus.rx;

`ifdef UART_RX_MAJ_VOTE_EN
  logic prev2_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev2_rx <= 1'b1;
    else        prev2_rx <= prev_rx;
  end

  assign s = (bus.rx & prev_rx) | (bus.rx & prev2_rx) | (prev_rx & prev2_rx);
`else
  assign s = bus.rx;
`endif

  // NOTE: every register below is assigned with <= so all branches see the pre-edge
  // values; a blocking assignment here would let later lines read already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      prev_rx   <= 1'b1;
      rx_rdy_q  <= 1'b0;
      rx_data_q <= '0;
      frm_err_q <= 1'b0;
    end else begin
      prev_rx   <= bus.rx;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;

      if (state != IDLE)
        baud_cnt <= tick ? FULL : baud_cnt - CW'(1);

      case (state)
        IDLE: begin
          // A held-low line keeps prev_rx low, so a break cannot retrigger.
          if (start_edge) begin
            baud_cnt <= HALF;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!s) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          // Leaving mid-stop-bit lets the next start edge arrive with no idle gap.
          if (tick) begin
            if (s) begin
              rx_data_q <= shift_q;
              rx_rdy_q  <= 1'b1;
            end else begin
              frm_err_q <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_rdy  = rx_rdy_q;
  assign bus.rx_data = rx_data_q;
  assign bus.frm_err = frm_err_q;
  assign bus.busy    = (state != IDLE);

endmodule
